// File: rtl/lsu_align.sv
// Load/store alignment unit: maps MEM-stage byte accesses onto four dmem byte lanes,
// splitting accesses that cross a word boundary and decoding a single GPIO register.
module lsu_align #(
    parameter logic [31:0] IO_BASE = 32'h2000_0000,
    parameter int          GPIO_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       dmem_addr,
    output logic [3:0]        dmem_we,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [GPIO_W-1:0] gpio_out
);

    typedef enum logic {
        IDLE,
        SPLIT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] buf_q;

    logic [1:0]  off;
    logic [3:0]  size_mask;
    logic [7:0]  lane_span;
    logic [3:0]  buf_lanes;
    logic        illegal;
    logic        is_io;
    logic        is_split;
    logic [31:0] wa;
    logic [31:0] wrot;
    logic [31:0] merged;
    logic [31:0] load_word;
    logic [31:0] load_ext;
    logic [31:0] gpio_ext;

    logic        rsp_valid_next;
    logic [31:0] rsp_rdata_next;
    logic        buf_load;
    logic        gpio_load;

    function automatic logic [31:0] rotl8(input logic [31:0] x, input logic [1:0] k);
        logic [31:0] r;
        case (k)
            2'd0:    r = x;
            2'd1:    r = {x[23:0], x[31:24]};
            2'd2:    r = {x[15:0], x[31:16]};
            default: r = {x[7:0],  x[31:8]};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rotr8(input logic [31:0] x, input logic [1:0] k);
        logic [31:0] r;
        case (k)
            2'd0:    r = x;
            2'd1:    r = {x[7:0],  x[31:8]};
            2'd2:    r = {x[15:0], x[31:16]};
            default: r = {x[23:0], x[31:24]};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{raw[7]}}, raw[7:0]};
            3'b100:  r = {24'd0, raw[7:0]};
            3'b001:  r = {{16{raw[15]}}, raw[15:0]};
            3'b101:  r = {16'd0, raw[15:0]};
            3'b010:  r = raw;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Lanes touched by the access, as an 8-lane window: low nibble is beat 1, high nibble beat 2.
    always_comb begin
        off       = req_addr[1:0];
        illegal   = 1'b0;
        size_mask = 4'b0000;
        case (req_funct3)
            3'b000, 3'b100: size_mask = 4'b0001;
            3'b001, 3'b101: size_mask = 4'b0011;
            3'b010:         size_mask = 4'b1111;
            default:        illegal   = 1'b1;
        endcase
        lane_span = {4'b0000, size_mask} << off;
        buf_lanes = 4'b1111 << off;
        is_io     = (req_addr[31:28] == IO_BASE[31:28]);
        is_split  = !is_io && (lane_span[7:4] != 4'b0000);
        wa        = {req_addr[31:2], 2'b00};
        wrot      = rotl8(req_wdata, off);
    end

    // Second beat merges the upper lanes captured from the first word with the fresh lower lanes.
    always_comb begin
        merged = 32'd0;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = buf_lanes[i] ? buf_q[8*i +: 8] : dmem_rdata[8*i +: 8];
        end
        load_word = (state == SPLIT) ? merged : dmem_rdata;
        load_ext  = extend(rotr8(load_word, off), req_funct3);
        gpio_ext  = 32'd0;
        gpio_ext[GPIO_W-1:0] = gpio_out;
    end

    always_comb begin
        state_next     = state;
        stall          = 1'b0;
        dmem_addr      = wa;
        dmem_we        = 4'b0000;
        dmem_wdata     = wrot;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata;
        buf_load       = 1'b0;
        gpio_load      = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (illegal) begin
                        rsp_valid_next = 1'b1;
                        rsp_rdata_next = 32'd0;
                    end else if (is_io) begin
                        gpio_load      = req_we;
                        rsp_valid_next = 1'b1;
                        rsp_rdata_next = req_we ? 32'd0 : gpio_ext;
                    end else if (is_split) begin
                        stall      = 1'b1;
                        dmem_we    = req_we ? lane_span[3:0] : 4'b0000;
                        buf_load   = 1'b1;
                        state_next = SPLIT;
                    end else begin
                        dmem_we        = req_we ? lane_span[3:0] : 4'b0000;
                        rsp_valid_next = 1'b1;
                        rsp_rdata_next = req_we ? 32'd0 : load_ext;
                    end
                end
            end
            SPLIT: begin
                dmem_addr      = wa + 32'd4;
                dmem_we        = req_we ? lane_span[7:4] : 4'b0000;
                rsp_valid_next = 1'b1;
                rsp_rdata_next = req_we ? 32'd0 : load_ext;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Reset must not commit a write or hold the pipeline, even mid-split.
        if (rst) begin
            stall   = 1'b0;
            dmem_we = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            buf_q     <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            gpio_out  <= '0;
        end else begin
            state     <= state_next;
            rsp_valid <= rsp_valid_next;
            rsp_rdata <= rsp_rdata_next;
            if (buf_load) begin
                buf_q <= dmem_rdata;
            end
            if (gpio_load) begin
                gpio_out <= req_wdata[GPIO_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align: directed requests push expected responses, a negedge
// monitor pops them; a byte-lane memory model sits behind the dmem port.
module tb_lsu_align;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [7:0]  gpio_out;

    logic [31:0] mem [0:1023];
    logic        memClear;

    typedef struct {
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    lsu_align #(
        .IO_BASE(32'h2000_0000),
        .GPIO_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .dmem_addr (dmem_addr),
        .dmem_we   (dmem_we),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .gpio_out  (gpio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign dmem_rdata = mem[dmem_addr[11:2]];

    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (dmem_we[l]) mem[dmem_addr[11:2]][8*l +: 8] <= dmem_wdata[8*l +: 8];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // beats=0 means the request must not produce a response.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp, input int beats);
        exp_t e;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        if (beats > 0) begin
            e.rdata = exp;
            e.due   = cyc + beats;
            sbq.push_back(e);
        end
        #1;
    endtask

    task automatic nextBeat();
        @(posedge clk);
        #2;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp: got rdata 0x%08h at cycle %0d, required no response", rsp_rdata, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        memClear   = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_01FE;
        req_wdata  = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_stall", stall, 0);
        checkOutput("reset_we", dmem_we, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 0);
        checkOutput("reset_gpio", gpio_out, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        memClear  = 1'b0;
        req_valid = 1'b0;

        // Aligned word store and load
        applyStimulus(1, 3'b010, 32'h100, 32'h1122_3344, 32'h0, 1);
        checkOutput("t1_we", dmem_we, 4'b1111);
        checkOutput("t1_addr", dmem_addr, 32'h100);
        checkOutput("t1_wdata", dmem_wdata, 32'h1122_3344);
        checkOutput("t1_stall", stall, 0);
        applyStimulus(0, 3'b010, 32'h100, 32'h0, 32'h1122_3344, 1);
        idleCycle();

        // Byte store into lane 2, then signed/unsigned/halfword reads
        applyStimulus(1, 3'b010, 32'h100, 32'h0, 32'h0, 1);
        applyStimulus(1, 3'b000, 32'h102, 32'h0000_00AB, 32'h0, 1);
        checkOutput("t2_we", dmem_we, 4'b0100);
        checkOutput("t2_lane2", dmem_wdata[23:16], 8'hAB);
        applyStimulus(0, 3'b010, 32'h100, 32'h0, 32'h00AB_0000, 1);
        applyStimulus(0, 3'b000, 32'h102, 32'h0, 32'hFFFF_FFAB, 1);
        applyStimulus(0, 3'b100, 32'h102, 32'h0, 32'h0000_00AB, 1);
        applyStimulus(0, 3'b001, 32'h102, 32'h0, 32'h0000_00AB, 1);
        checkOutput("t2_lh_nosplit", stall, 0);
        idleCycle();

        // Misaligned word store/load across 0x200/0x204
        applyStimulus(1, 3'b010, 32'h203, 32'hDEAD_BEEF, 32'h0, 2);
        checkOutput("t3_c0_stall", stall, 1);
        checkOutput("t3_c0_addr", dmem_addr, 32'h200);
        checkOutput("t3_c0_we", dmem_we, 4'b1000);
        checkOutput("t3_c0_lane3", dmem_wdata[31:24], 8'hEF);
        nextBeat();
        checkOutput("t3_c1_stall", stall, 0);
        checkOutput("t3_c1_addr", dmem_addr, 32'h204);
        checkOutput("t3_c1_we", dmem_we, 4'b0111);
        checkOutput("t3_c1_lanes", dmem_wdata[23:0], 24'hDEADBE);
        applyStimulus(0, 3'b010, 32'h203, 32'h0, 32'hDEAD_BEEF, 2);
        checkOutput("t3_lw_stall", stall, 1);
        nextBeat();
        idleCycle();

        // Split halfword load, signed then unsigned
        applyStimulus(1, 3'b000, 32'h1FF, 32'h0000_0034, 32'h0, 1);
        checkOutput("t4_sb_we3", dmem_we, 4'b1000);
        applyStimulus(1, 3'b000, 32'h200, 32'h0000_0092, 32'h0, 1);
        checkOutput("t4_sb_we0", dmem_we, 4'b0001);
        applyStimulus(0, 3'b001, 32'h1FF, 32'h0, 32'hFFFF_9234, 2);
        checkOutput("t4_lh_stall", stall, 1);
        nextBeat();
        checkOutput("t4_lh_addr2", dmem_addr, 32'h200);
        applyStimulus(0, 3'b101, 32'h1FF, 32'h0, 32'h0000_9234, 2);
        nextBeat();
        idleCycle();

        // GPIO register and illegal funct3
        applyStimulus(1, 3'b010, 32'h2000_0000, 32'h0000_00A5, 32'h0, 1);
        checkOutput("t5_io_we", dmem_we, 0);
        checkOutput("t5_io_stall", stall, 0);
        applyStimulus(0, 3'b010, 32'h2000_0000, 32'h0, 32'h0000_00A5, 1);
        checkOutput("t5_gpio", gpio_out, 8'hA5);
        applyStimulus(1, 3'b011, 32'h100, 32'hFFFF_FFFF, 32'h0, 1);
        checkOutput("t5_illegal_we", dmem_we, 0);
        applyStimulus(0, 3'b111, 32'h100, 32'h0, 32'h0, 1);
        applyStimulus(0, 3'b010, 32'h100, 32'h0, 32'h00AB_0000, 1);
        applyStimulus(1, 3'b000, 32'h2000_0003, 32'h0000_005A, 32'h0, 1);
        applyStimulus(0, 3'b100, 32'h2000_0001, 32'h0, 32'h0000_005A, 1);
        checkOutput("t5_gpio_off", gpio_out, 8'h5A);

        // Reset while the second beat of a split store is pending
        applyStimulus(1, 3'b010, 32'h1FE, 32'hCAFE_F00D, 32'h0, 0);
        checkOutput("t6_c0_we", dmem_we, 4'b1100);
        checkOutput("t6_c0_stall", stall, 1);
        checkOutput("t6_c0_wdata", dmem_wdata, 32'hF00D_CAFE);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_we", dmem_we, 0);
        checkOutput("t6_rst_stall", stall, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        #1;
        checkOutput("t6_rsp_valid", rsp_valid, 0);
        checkOutput("t6_gpio", gpio_out, 0);
        checkOutput("t6_rsp_rdata", rsp_rdata, 0);
        applyStimulus(0, 3'b010, 32'h1FC, 32'h0, 32'hF00D_0000, 1);
        checkOutput("t6_idle_stall", stall, 0);
        checkOutput("t6_idle_addr", dmem_addr, 32'h1FC);
        applyStimulus(0, 3'b010, 32'h200, 32'h0, 32'hEF00_0092, 1);
        idleCycle();

        repeat (4) @(posedge clk);
        #1;
        checkOutput("pending_rsp", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
